mm_sequencer: RTL and testbench

//  Sequences the 8x8 matrix-vector multiply datapath (per-row A FIFOs, B FIFO, MAC array).
//  On start, fetches A rows and vector B from a 64-bit memory port and unpacks them byte-wise into the FIFOs.

---
 rtl/mm_pkg.sv | 21 ++
 rtl/mm_skew_gen.sv | 49 ++++
 rtl/mm_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mm_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and default dimensions for the matrix-vector multiply sequencer.
package mm_pkg;

  localparam int unsigned DEF_ROWS      = 8;
  localparam int unsigned DEF_COLS      = 8;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_MEM_W     = DEF_COLS * DEF_DATA_W;
  localparam int unsigned DEF_ADDR_W    = 32;
  localparam int unsigned DEF_DRAIN_CYC = 2;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StFill,
    StExec,
    StDrain,
    StDone
  } mm_state_t;

endpackage

// File: rtl/mm_skew_gen.sv
// Systolic skew generator: turns the EXEC step counter into per-FIFO pop strobes
// and the matching MAC enables, which trail the pops by the FIFO read latency.
module mm_skew_gen
  import mm_pkg::*;
#(
  parameter int unsigned ROWS = DEF_ROWS,
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned KW   = $clog2(ROWS + COLS)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_active,
  input  logic            i_clr,
  input  logic [KW-1:0]   i_k,
  output logic [ROWS:0]   o_rden,
  output logic [ROWS-1:0] o_mac_en
);

  logic [ROWS:0]   w_rden;
  logic [ROWS-1:0] r_mac_en;

  // Row i reads during steps i..i+COLS-1; the B FIFO reads during steps 0..COLS-1.
  always_comb begin
    int kk;
    kk     = int'(i_k);
    w_rden = '0;
    if (i_active) begin
      for (int i = 0; i < int'(ROWS); i++) begin
        w_rden[i] = (kk >= i) && (kk < i + int'(COLS));
      end
      w_rden[ROWS] = kk < int'(COLS);
    end
  end

  // MAC enables follow the A-FIFO pops by one cycle; an abort flushes them at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mac_en <= '0;
    end else if (i_clr) begin
      r_mac_en <= '0;
    end else begin
      r_mac_en <= w_rden[ROWS-1:0];
    end
  end

  assign o_rden   = w_rden;
  assign o_mac_en = r_mac_en;

endmodule

// File: rtl/mm_sequencer.sv
// Matrix-vector multiply sequencer: fetches A rows and vector B word by word,
// unpacks each word byte-wise into its FIFO, then runs the skewed read/MAC phase,
// drains the pipeline and pulses done.
module mm_sequencer
  import mm_pkg::*;
#(
  parameter int unsigned       ROWS      = DEF_ROWS,
  parameter int unsigned       COLS      = DEF_COLS,
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter int unsigned       MEM_W     = COLS * DATA_W,
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       DRAIN_CYC = DEF_DRAIN_CYC
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_clr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_read,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_waitrequest,
  input  logic [MEM_W-1:0]  i_mem_readdata,
  input  logic              i_mem_readdatavalid,
  output logic [ROWS:0]     o_fifo_wren,
  output logic [DATA_W-1:0] o_fifo_wdata,
  output logic [ROWS:0]     o_fifo_rden,
  output logic [ROWS-1:0]   o_mac_en,
  output logic              o_mac_clr
);

  localparam int unsigned WW = $clog2(ROWS + 1);
  localparam int unsigned KW = $clog2(ROWS + COLS);
  localparam int unsigned JW = $clog2(COLS);

  mm_state_t         r_state;
  logic [WW-1:0]     r_w;
  logic [KW-1:0]     r_k;
  logic [JW-1:0]     r_j;
  logic [MEM_W-1:0]  r_data;
  logic              r_mem_read;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ROWS:0]     r_fifo_wren;
  logic [DATA_W-1:0] r_fifo_wdata;
  logic              r_mac_clr;

  logic [WW-1:0]     w_w_inc;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_exec;

  assign w_w_inc     = r_w + WW'(1);
  assign w_next_addr = BASE_ADDR + (ADDR_W'(w_w_inc) << 3);
  assign w_exec      = (r_state == StExec);

  // Main sequencing FSM; fetch, unpack and all memory/push outputs are registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_w          <= '0;
      r_k          <= '0;
      r_j          <= '0;
      r_data       <= '0;
      r_mem_read   <= 1'b0;
      r_mem_addr   <= '0;
      r_fifo_wren  <= '0;
      r_fifo_wdata <= '0;
      r_mac_clr    <= 1'b0;
    end else begin
      r_mac_clr <= 1'b0;
      if (i_clr) begin
        // Abort wins over everything, including a simultaneous start.
        r_state     <= StIdle;
        r_mem_read  <= 1'b0;
        r_mem_addr  <= '0;
        r_fifo_wren <= '0;
        r_mac_clr   <= 1'b1;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_start) begin
              r_state    <= StReq;
              r_w        <= '0;
              r_mem_read <= 1'b1;
              r_mem_addr <= BASE_ADDR;
              r_mac_clr  <= 1'b1;
            end
          end
          StReq: begin
            if (!i_mem_waitrequest) begin
              r_mem_read <= 1'b0;
              r_state    <= StWait;
            end
          end
          StWait: begin
            if (i_mem_readdatavalid) begin
              // Byte 0 goes out immediately; the rest is kept pre-shifted.
              r_data       <= i_mem_readdata >> DATA_W;
              r_fifo_wdata <= i_mem_readdata[DATA_W-1:0];
              r_fifo_wren  <= {{ROWS{1'b0}}, 1'b1} << r_w;
              r_j          <= '0;
              r_state      <= StFill;
            end
          end
          StFill: begin
            if (r_j == JW'(COLS - 1)) begin
              r_fifo_wren <= '0;
              if (r_w == WW'(ROWS)) begin
                r_k     <= '0;
                r_state <= StExec;
              end else begin
                r_w        <= w_w_inc;
                r_mem_read <= 1'b1;
                r_mem_addr <= w_next_addr;
                r_state    <= StReq;
              end
            end else begin
              r_j          <= r_j + JW'(1);
              r_fifo_wdata <= r_data[DATA_W-1:0];
              r_data       <= r_data >> DATA_W;
            end
          end
          StExec: begin
            if (r_k == KW'(ROWS + COLS - 2)) begin
              r_k     <= '0;
              r_state <= StDrain;
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
          StDrain: begin
            if (r_k == KW'(DRAIN_CYC - 1)) begin
              r_state <= StDone;
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
          StDone: begin
            r_state <= StIdle;
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

  mm_skew_gen #(
    .ROWS (ROWS),
    .COLS (COLS),
    .KW   (KW)
  ) u_skew_gen (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_active (w_exec),
    .i_clr    (i_clr),
    .i_k      (r_k),
    .o_rden   (o_fifo_rden),
    .o_mac_en (o_mac_en)
  );

  assign o_busy       = (r_state != StIdle);
  assign o_done       = (r_state == StDone);
  assign o_mem_read   = r_mem_read;
  assign o_mem_addr   = r_mem_addr;
  assign o_fifo_wren  = r_fifo_wren;
  assign o_fifo_wdata = r_fifo_wdata;
  assign o_mac_clr    = r_mac_clr;

endmodule

// File: tb/tb_mm_sequencer.sv
// Self-checking bench for mm_sequencer: a memory responder, a FIFO/MAC model that
// recomputes the matrix-vector product, a job table and a few hand-written corner cases.
module tb_mm_sequencer;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int DRAIN = 2;

  logic        clk, rst_n, start, clr, wreq, rvalid;
  logic [63:0] rdata;
  logic        busy, done, mem_read, mac_clr;
  logic [31:0] mem_addr;
  logic [ROWS:0]   wren, rden;
  logic [7:0]      wdata;
  logic [ROWS-1:0] mac_en;

  mm_sequencer u_dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_start             (start),
    .i_clr               (clr),
    .o_busy              (busy),
    .o_done              (done),
    .o_mem_read          (mem_read),
    .o_mem_addr          (mem_addr),
    .i_mem_waitrequest   (wreq),
    .i_mem_readdata      (rdata),
    .i_mem_readdatavalid (rvalid),
    .o_fifo_wren         (wren),
    .o_fifo_wdata        (wdata),
    .o_fifo_rden         (rden),
    .o_mac_en            (mac_en),
    .o_mac_clr           (mac_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sw;        // word index that gets the stall / valid delay
    int ws;        // waitrequest cycles on that word
    int vd;        // extra readdatavalid delay on that word
    int busy_at;   // cycle offset of a stray start while busy (-1 none)
    int clr_k;     // EXEC step at which clr is raised (-1 none)
    int exp_lat;
    int exp_done;
    int exp_mc;
  } job_t;

  job_t jobs[8];
  int   n_vec, n_err, cur_job, cyc;

  // responder state
  int          stall_word, stall_left, vd_cfg, pend_dly;
  bit          pend, stray, prev_stalled;
  logic [63:0] pend_data;
  logic [31:0] prev_addr;

  // monitor / model state
  int          n_reads, addr_err, stall_addr_err, push_err, onehot_err, skew_err;
  int          done_cnt, done_cyc, mac_clr_cnt, ek;
  bit          armed;
  int          push_cnt[ROWS+1];
  int          rp[ROWS+1];
  logic [7:0]  fmem[ROWS+1][COLS];
  logic [7:0]  a_out[ROWS];
  logic [7:0]  b_stage[ROWS];
  int          acc[ROWS];

  function automatic logic [7:0] mem_byte(int w, int j);
    return (w < ROWS) ? 8'(8 * w + j) : 8'(j + 1);
  endfunction

  function automatic logic [63:0] mem_word(int w);
    logic [63:0] v;
    for (int j = 0; j < COLS; j++) v[8*j +: 8] = mem_byte(w, j);
    return v;
  endfunction

  function automatic logic [7:0] pop(int f);
    logic [7:0] v;
    if (rp[f] < push_cnt[f] && rp[f] < COLS) v = fmem[f][rp[f]];
    else begin
      v = 8'h00;
      skew_err++;
    end
    rp[f]++;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (job %0d): got %0d, expected %0d", nm, cur_job, act, exp);
    end
  endtask

  task automatic mon_clear();
    n_reads = 0; addr_err = 0; stall_addr_err = 0; push_err = 0; onehot_err = 0;
    skew_err = 0; done_cnt = 0; done_cyc = -1; mac_clr_cnt = 0; ek = 0; armed = 0;
    pend = 0; pend_dly = 0; stray = 0; prev_stalled = 0; prev_addr = '0;
    stall_word = 0; stall_left = 0; vd_cfg = 0;
    for (int f = 0; f <= ROWS; f++) begin
      push_cnt[f] = 0;
      rp[f] = 0;
    end
    for (int i = 0; i < ROWS; i++) begin
      a_out[i] = '0;
      b_stage[i] = '0;
      acc[i] = 0;
    end
  endtask

  // One clock: observe DUT outputs at the falling edge, update the model, drive memory.
  task automatic step();
    logic [ROWS:0]   exp_rd;
    logic [ROWS-1:0] exp_mac;
    int km;
    @(negedge clk);
    cyc++;
    if (mac_clr === 1'b1) begin
      mac_clr_cnt++;
      for (int i = 0; i < ROWS; i++) acc[i] = 0;
    end
    for (int i = 0; i < ROWS; i++)
      if (mac_en[i] === 1'b1) acc[i] += int'(a_out[i]) * int'(b_stage[i]);
    for (int i = ROWS - 1; i > 0; i--) b_stage[i] = b_stage[i-1];
    if (rden[ROWS] === 1'b1) b_stage[0] = pop(ROWS);
    for (int i = 0; i < ROWS; i++) if (rden[i] === 1'b1) a_out[i] = pop(i);
    if (armed) begin
      exp_rd = '0;
      exp_mac = '0;
      km = ek - 1;
      for (int i = 0; i < ROWS; i++) begin
        exp_rd[i]  = (ek <= ROWS + COLS - 2) && (ek >= i) && (ek < i + COLS);
        exp_mac[i] = (km >= 0) && (km <= ROWS + COLS - 2) && (km >= i) && (km < i + COLS);
      end
      exp_rd[ROWS] = (ek < COLS);
      if (rden !== exp_rd || mac_en !== exp_mac) skew_err++;
      ek++;
      if (ek > ROWS + COLS - 1 + DRAIN) armed = 0;
    end else if (rden !== '0 || mac_en !== '0) begin
      skew_err++;
    end
    if (wren !== '0) begin
      if ($countones(wren) != 1) onehot_err++;
      for (int f = 0; f <= ROWS; f++) begin
        if (wren[f] === 1'b1) begin
          if (push_cnt[f] < COLS) begin
            if (wdata !== mem_byte(f, push_cnt[f])) push_err++;
            fmem[f][push_cnt[f]] = wdata;
          end else push_err++;
          push_cnt[f]++;
          if (f == ROWS && push_cnt[f] == COLS) begin
            armed = 1;
            ek = 0;
          end
        end
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    rvalid = 1'b0;
    if (pend) begin
      if (pend_dly == 0) begin
        rvalid = 1'b1;
        rdata = pend_data;
        pend = 0;
      end else pend_dly--;
    end
    if (stray) begin
      rvalid = 1'b1;
      rdata = '1;
      stray = 0;
    end
    wreq = 1'b0;
    if (mem_read === 1'b1) begin
      if (prev_stalled && mem_addr !== prev_addr) stall_addr_err++;
      if (mem_addr == 32'(stall_word * 8) && stall_left > 0) begin
        wreq = 1'b1;
        stall_left--;
        prev_stalled = 1;
        prev_addr = mem_addr;
      end else begin
        prev_stalled = 0;
        if (mem_addr !== 32'(n_reads * 8)) addr_err++;
        n_reads++;
        pend = 1;
        pend_dly = (mem_addr == 32'(stall_word * 8)) ? vd_cfg : 0;
        pend_data = mem_word(int'(mem_addr >> 3));
      end
    end else prev_stalled = 0;
  endtask

  task automatic run_job(input job_t jb);
    int t0, clr_cyc, sum, e;
    bit clr_sent;
    logic busy_after, post_busy, post_mc;
    logic [63:0] post_strobes;
    mon_clear();
    stall_word = jb.sw;
    stall_left = jb.ws;
    vd_cfg = jb.vd;
    t0 = cyc;
    start = 1'b1;
    clr_sent = 0;
    clr_cyc = -1;
    busy_after = 1'bx;
    post_busy = 1'bx;
    post_mc = 1'bx;
    post_strobes = 'x;
    for (int n = 1; n <= 400; n++) begin
      step();
      start = (jb.busy_at == cyc - t0);
      if (clr_sent && cyc == clr_cyc + 1) begin
        post_busy = busy;
        post_mc = mac_clr;
        post_strobes = 64'({rden, mac_en, wren, mem_read});
        clr = 1'b0;
      end
      if (!clr_sent && jb.clr_k >= 0 && armed && ek == jb.clr_k + 1) begin
        clr = 1'b1;
        armed = 0;
        clr_sent = 1;
        clr_cyc = cyc;
      end
      if (done_cnt > 0 && cyc == done_cyc + 1) busy_after = busy;
      if (done_cnt > 0 && cyc >= done_cyc + 2) break;
      if (clr_sent && cyc >= clr_cyc + 130) break;
    end
    start = 1'b0;
    clr = 1'b0;
    chk("done_pulses", 64'(done_cnt), 64'(jb.exp_done));
    chk("mac_clr_cycles", 64'(mac_clr_cnt), 64'(jb.exp_mc));
    chk("skew_errors", 64'(skew_err), 0);
    if (jb.clr_k >= 0) begin
      chk("busy_after_clr", 64'(post_busy), 0);
      chk("mac_clr_after_clr", 64'(post_mc), 1);
      chk("strobes_after_clr", post_strobes, 0);
      chk("idle_at_end", 64'(busy), 0);
    end else begin
      chk("latency", 64'(done_cyc - t0), 64'(jb.exp_lat));
      chk("reads", 64'(n_reads), 9);
      chk("addr_errors", 64'(addr_err + stall_addr_err), 0);
      sum = 0;
      for (int f = 0; f <= ROWS; f++) sum += push_cnt[f];
      chk("pushes", 64'(sum), 72);
      chk("push_errors", 64'(push_err + onehot_err), 0);
      chk("busy_after_done", 64'(busy_after), 0);
      for (int i = 0; i < ROWS; i++) begin
        e = 0;
        for (int j = 0; j < COLS; j++) e += int'(mem_byte(i, j)) * int'(mem_byte(ROWS, j));
        chk($sformatf("cout_row%0d", i), 64'(acc[i]), 64'(e));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sum;
    n_vec = 0; n_err = 0; cur_job = -1; cyc = 0;
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; wreq = 1'b0; rvalid = 1'b0; rdata = '0;
    mon_clear();

    //                sw ws vd busy clr lat done mc
    jobs[0] = '{0, 0, 0, -1, -1, 108, 1, 1};
    jobs[1] = '{2, 3, 4, -1, -1, 115, 1, 1};
    jobs[2] = '{0, 0, 0, 20, -1, 108, 1, 1};
    jobs[3] = '{0, 5, 0, -1, -1, 113, 1, 1};
    jobs[4] = '{8, 0, 2, -1, -1, 110, 1, 1};
    jobs[5] = '{3, 50, 0, -1, -1, 158, 1, 1};
    jobs[6] = '{0, 0, 0, -1, 5, 0, 0, 2};
    jobs[7] = '{0, 0, 0, -1, -1, 108, 1, 1};

    // Reset state, then release at a falling edge.
    step();
    step();
    chk("reset_outputs", 64'({busy, done, mem_read, wren, wdata, rden, mac_en, mac_clr}), 0);
    chk("reset_addr", 64'(mem_addr), 0);
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("idle_after_release", 64'({busy, mem_read}), 0);

    // clr together with start in IDLE: abort wins.
    start = 1'b1;
    clr = 1'b1;
    step();
    start = 1'b0;
    clr = 1'b0;
    chk("clr_start_busy", 64'(busy), 0);
    chk("clr_start_mac_clr", 64'(mac_clr), 1);
    chk("clr_start_mem_read", 64'(mem_read), 0);
    step();
    chk("clr_start_mac_clr_drop", 64'(mac_clr), 0);

    for (int j = 0; j < 8; j++) begin
      cur_job = j;
      run_job(jobs[j]);
      step();
    end

    // Reset while waiting for read data; the late valid and a stray valid must be ignored.
    cur_job = 8;
    mon_clear();
    vd_cfg = 4;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("in_wait_busy", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midjob_reset_outputs", 64'({busy, done, mem_read, wren, rden, mac_en, mac_clr}), 0);
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) step();
    stray = 1;
    for (int n = 0; n < 4; n++) step();
    sum = 0;
    for (int f = 0; f <= ROWS; f++) sum += push_cnt[f];
    chk("late_valid_pushes", 64'(sum), 0);
    chk("late_valid_busy", 64'(busy), 0);
    chk("late_valid_mem_read", 64'(mem_read), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
